// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter and sequencer for a shared NUM_REQ:1 data mux.
//   Picks one valid/ready requester, drives the mux select and registers the
//   selected beat into a single valid/ready output stage. A multi-beat packet
//   keeps the grant (LOCK state) until its last beat so the select is stable
//   for the whole packet.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous reset, active-low
//   req_valid  - per-requester beat valid
//   req_last   - per-requester last beat of packet
//   req_data   - packed beats, requester i at [i*DATA_W +: DATA_W]
//   req_ready  - per-requester accept (one-hot or zero)
//   out_valid  - registered output beat valid
//   out_data   - registered output beat
//   out_last   - registered last flag
//   out_src    - registered index of the requester that produced out_data
//   out_ready  - downstream accept
//   sel        - combinational mux select (current grant index)
//   locked     - high while a packet holds the grant
module mux_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic [SRC_W-1:0]          sel,
  output logic                      locked
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Index increment with wrap from NUM_REQ-1 back to 0 (NUM_REQ need not be a power of 2).
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    logic [SRC_W-1:0] res;
    if (idx == SRC_W'(NUM_REQ - 1)) begin
      res = {SRC_W{1'b0}};
    end else begin
      res = idx + SRC_W'(1);
    end
    return res;
  endfunction

  state_e              state_r;
  state_e              state_nxt_s;
  logic [SRC_W-1:0]    rr_ptr_r;
  logic [SRC_W-1:0]    rr_ptr_nxt_s;
  logic [SRC_W-1:0]    lock_id_r;
  logic [SRC_W-1:0]    lock_id_nxt_s;

  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                out_last_r;
  logic [SRC_W-1:0]    out_src_r;

  logic                arb_found_s;
  logic [SRC_W-1:0]    arb_idx_s;
  logic                can_load_s;
  logic                grant_ok_s;
  logic [SRC_W-1:0]    sel_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic                transfer_s;
  logic                sel_last_s;
  logic [DATA_W-1:0]   sel_data_s;

  // Round-robin scan: first valid requester starting at rr_ptr, wrapping around.
  always_comb begin
    logic [SRC_W-1:0] scan_v;
    arb_found_s = 1'b0;
    arb_idx_s   = rr_ptr_r;
    scan_v      = rr_ptr_r;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_found_s && req_valid[scan_v]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = scan_v;
      end else begin
        arb_found_s = arb_found_s;
      end
      scan_v = next_idx(scan_v);
    end
  end

  // Grant select and handshake. Ready is held low during reset so no beat is
  // accepted and then discarded by the reset of the output stage.
  always_comb begin
    can_load_s = !out_valid_r || out_ready;
    if (state_r == ST_LOCK) begin
      sel_s      = lock_id_r;
      grant_ok_s = 1'b1;
    end else begin
      sel_s      = arb_idx_s;
      grant_ok_s = arb_found_s;
    end
    req_ready_s = {NUM_REQ{1'b0}};
    if (rst_n && can_load_s && grant_ok_s) begin
      req_ready_s[sel_s] = 1'b1;
    end else begin
      req_ready_s = {NUM_REQ{1'b0}};
    end
    transfer_s = req_valid[sel_s] && req_ready_s[sel_s];
    sel_last_s = req_last[sel_s];
  end

  // Data mux: only feeds the output register, never a combinational output.
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_s == SRC_W'(i)) begin
        sel_data_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Next-state logic for the ARB/LOCK sequencer and the round-robin pointer.
  always_comb begin
    state_nxt_s   = state_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    lock_id_nxt_s = lock_id_r;
    case (state_r)
      ST_ARB: begin
        if (transfer_s) begin
          if (sel_last_s) begin
            rr_ptr_nxt_s = next_idx(sel_s);
          end else begin
            lock_id_nxt_s = sel_s;
            state_nxt_s   = ST_LOCK;
          end
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_LOCK: begin
        // No timeout: an idle locked requester keeps the grant.
        if (transfer_s && sel_last_s) begin
          rr_ptr_nxt_s = next_idx(lock_id_r);
          state_nxt_s  = ST_ARB;
        end else begin
          state_nxt_s = ST_LOCK;
        end
      end
      default: begin
        state_nxt_s = ST_ARB;
      end
    endcase
  end

  // Sequencer state, round-robin pointer and lock owner registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_ARB;
      rr_ptr_r  <= {SRC_W{1'b0}};
      lock_id_r <= {SRC_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
      lock_id_r <= lock_id_nxt_s;
    end
  end

  // Output stage: load on transfer, drain on accept, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
      out_src_r   <= {SRC_W{1'b0}};
    end else if (transfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_last_r  <= sel_last_s;
      out_src_r   <= sel_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign req_ready = req_ready_s;
  assign sel       = sel_s;
  assign locked    = (state_r == ST_LOCK);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_src   = out_src_r;

endmodule
